// File: rtl/echo_frame_tx.sv
// echo_frame_tx: transmit-side framer for the echo sink.
// Each accepted frame emits a sink-reset pulse, one header word carrying the
// delay, then i_len payload samples drained from an internal upstream FIFO.
// The sink only latches its delay on the first valid word after reset, so
// every frame re-arms it.
//
// Build option: define ECHO_TX_FLUSH_EN to add a FLUSH state that holds off
// o_done for <delay> idle cycles after the last payload word.
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_start             one-cycle frame request (sampled only in IDLE)
//   i_delay, i_len      frame delay and payload length, captured with i_start
//   s_valid/s_data      upstream samples; s_ready = FIFO not full (registered)
//   o_sink_rst          active-high reset to the echo sink
//   o_valid/o_data      header/payload word to the sink (o_data=0 when idle)
//   o_busy              frame in progress
//   o_done              one-cycle pulse at frame end
//   o_cfg_err           one-cycle pulse when i_start carries an illegal delay
module echo_frame_tx #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned DELAY_MIN  = 2,
  parameter int unsigned DELAY_MAX  = 102
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_delay,
  input  logic [LEN_WIDTH-1:0]  i_len,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  o_sink_rst,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_cfg_err
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_MAX = (RST_CYCLES > DELAY_MAX) ? RST_CYCLES : DELAY_MAX;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SRST,
    ST_HDR,
    ST_DATA,
`ifdef ECHO_TX_FLUSH_EN
    ST_FLUSH,
`endif
    ST_DONE
  } state_t;

  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   delay_q, delay_nxt;
  logic [LEN_WIDTH-1:0]    rem_q, rem_nxt;
  logic [CNT_W-1:0]        cnt_q, cnt_nxt;

  logic                    sink_rst_nxt, valid_nxt, done_nxt, cfg_err_nxt, busy_nxt;
  logic [DATA_WIDTH-1:0]   data_nxt;
  logic                    take_word;

  // Upstream FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [PTR_W:0]          count, count_nxt;
  logic                    fifo_wr, fifo_rd;
  logic                    delay_ok;

  // s_ready is the registered not-full flag, so a full FIFO refuses writes
  // even in a cycle where a pop frees a slot.
  assign fifo_wr   = s_valid && s_ready;
  assign count_nxt = count + (PTR_W+1)'(fifo_wr) - (PTR_W+1)'(fifo_rd);
  assign delay_ok  = (i_delay >= DATA_WIDTH'(DELAY_MIN)) && (i_delay <= DATA_WIDTH'(DELAY_MAX));

  // FIFO data array (contents need no reset; pointers define validity)
  always_ff @(posedge i_clk) begin
    if (fifo_wr) begin
      mem[wr_ptr] <= s_data;
    end
  end

  // FIFO pointers, occupancy and registered ready
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      s_ready <= 1'b1;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (fifo_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      count   <= count_nxt;
      s_ready <= (count_nxt != (PTR_W+1)'(FIFO_DEPTH));
    end
  end

  // Next state plus the output values that go with the state being entered
  always_comb begin
    state_nxt    = state;
    delay_nxt    = delay_q;
    rem_nxt      = rem_q;
    cnt_nxt      = cnt_q;
    sink_rst_nxt = 1'b0;
    valid_nxt    = 1'b0;
    data_nxt     = '0;
    done_nxt     = 1'b0;
    cfg_err_nxt  = 1'b0;
    take_word    = 1'b0;
    fifo_rd      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (i_start) begin
          if (delay_ok) begin
            state_nxt    = ST_SRST;
            delay_nxt    = i_delay;
            rem_nxt      = i_len;
            cnt_nxt      = CNT_W'(RST_CYCLES - 1);
            sink_rst_nxt = 1'b1;
          end else begin
            cfg_err_nxt  = 1'b1;
          end
        end
      end
      ST_SRST: begin
        if (cnt_q == '0) begin
          state_nxt    = ST_HDR;
          valid_nxt    = 1'b1;
          data_nxt     = delay_q;
        end else begin
          cnt_nxt      = cnt_q - CNT_W'(1);
          sink_rst_nxt = 1'b1;
        end
      end
      // An empty frame skips straight to DONE, even with flushing enabled.
      ST_HDR: begin
        if (rem_q == '0) begin
          state_nxt = ST_DONE;
          done_nxt  = 1'b1;
        end else begin
          state_nxt = ST_DATA;
          take_word = 1'b1;
        end
      end
      // rem_q counts words still to pop; zero means the last one is on o_data now.
      ST_DATA: begin
        if (rem_q == '0) begin
`ifdef ECHO_TX_FLUSH_EN
          state_nxt = ST_FLUSH;
          cnt_nxt   = CNT_W'(delay_q - DATA_WIDTH'(1));
`else
          state_nxt = ST_DONE;
          done_nxt  = 1'b1;
`endif
        end else begin
          take_word = 1'b1;
        end
      end
`ifdef ECHO_TX_FLUSH_EN
      ST_FLUSH: begin
        if (cnt_q == '0) begin
          state_nxt = ST_DONE;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt   = cnt_q - CNT_W'(1);
        end
      end
`endif
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Pop a sample when one is buffered; otherwise emit a bubble and hold the count.
    if (take_word && (count != '0)) begin
      fifo_rd   = 1'b1;
      valid_nxt = 1'b1;
      data_nxt  = mem[rd_ptr];
      rem_nxt   = rem_q - LEN_WIDTH'(1);
    end
  end

  assign busy_nxt = (state_nxt != ST_IDLE);

  // State register and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      delay_q    <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      o_sink_rst <= 1'b0;
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_cfg_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      delay_q    <= delay_nxt;
      rem_q      <= rem_nxt;
      cnt_q      <= cnt_nxt;
      o_sink_rst <= sink_rst_nxt;
      o_valid    <= valid_nxt;
      o_data     <= data_nxt;
      o_busy     <= busy_nxt;
      o_done     <= done_nxt;
      o_cfg_err  <= cfg_err_nxt;
    end
  end

endmodule
